// File: rtl/hls_call_sequencer_pkg.sv
// Shared state encoding and default sizing for the HLS call sequencer.
package hls_seq_pkg;

   localparam int ITER_W_DEF         = 16;
   localparam int TIMEOUT_W_DEF      = 24;
   localparam int TIMEOUT_CYCLES_DEF = 1000000;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      BUF_CALL = 3'd1,
      BUF_WAIT = 3'd2,
      FLT_CALL = 3'd3,
      FLT_WAIT = 3'd4
   } seq_state_e;

endpackage

// File: rtl/hls_call_sequencer_if.sv
// Call/return valid-stall conduit of one HLS component.
// The sequencer takes the master side; the component is the slave.
interface hls_call_if;

   logic call_valid;
   logic call_stall;
   logic return_valid;
   logic return_stall;

   modport master (
      output call_valid,
      output return_stall,
      input  call_stall,
      input  return_valid
   );

   modport slave (
      input  call_valid,
      input  return_stall,
      output call_stall,
      output return_valid
   );

endinterface

// File: rtl/hls_call_sequencer_port.sv
// One HLS component's call/return handshake plus its per-invocation timeout.
// The top FSM issues and cancels invocations; this block reports the accepts.
module hls_call_port
   import hls_seq_pkg::*;
#(
   parameter int TIMEOUT_W      = TIMEOUT_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_issue,
   input  logic       i_cancel,
   input  logic       i_idle,
   hls_call_if.master bus,
   output logic       o_call_accepted,
   output logic       o_return_accepted,
   output logic       o_timed_out
);

   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);

   logic                 r_call_valid;
   logic                 r_waiting;
   logic [TIMEOUT_W-1:0] r_to_cnt;
   logic                 w_active;

   assign w_active          = r_call_valid | r_waiting;
   assign o_call_accepted   = r_call_valid & ~bus.call_stall;
   assign o_return_accepted = r_waiting & bus.return_valid;
   assign o_timed_out       = TO_EN && w_active && (r_to_cnt == TO_LAST);

   assign bus.call_valid    = r_call_valid;
   // Returns are also taken while the sequencer is idle so stale ones drain.
   assign bus.return_stall  = ~(r_waiting | i_idle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_call_valid <= 1'b0;
         r_waiting    <= 1'b0;
      end else if (i_cancel) begin
         r_call_valid <= 1'b0;
         r_waiting    <= 1'b0;
      end else if (i_issue) begin
         r_call_valid <= 1'b1;
         r_waiting    <= 1'b0;
      end else if (o_call_accepted) begin
         r_call_valid <= 1'b0;
         r_waiting    <= 1'b1;
      end else if (o_return_accepted) begin
         r_waiting    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (i_issue) begin
         r_to_cnt <= '0;
      end else if (w_active) begin
         r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
      end
   end

endmodule

// File: rtl/hls_call_sequencer.sv
// Runs buffer_1 then filter_0 for num_iter iterations per start, with abort,
// per-invocation timeout and busy/done/error status.
module hls_call_sequencer
   import hls_seq_pkg::*;
#(
   parameter int ITER_W         = ITER_W_DEF,
   parameter int TIMEOUT_W      = TIMEOUT_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ITER_W-1:0] num_iter,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [ITER_W-1:0] iter_done,
   hls_call_if.master        buffer_1,
   hls_call_if.master        filter_0
);

   seq_state_e        r_state;
   seq_state_e        w_state_next;
   logic [ITER_W-1:0] r_num_iter;
   logic [ITER_W-1:0] r_iter_done;
   logic              r_done;
   logic              r_timeout_err;

   logic              w_buf_call_acc, w_buf_ret_acc, w_buf_to;
   logic              w_flt_call_acc, w_flt_ret_acc, w_flt_to;
   logic              w_buf_issue, w_flt_issue;
   logic              w_idle, w_cancel, w_timeout, w_start_acc;
   logic              w_last, w_iter_step, w_finish;
   logic [ITER_W-1:0] w_iter_inc;

   assign w_idle      = (r_state == IDLE);
   assign w_timeout   = w_buf_to | w_flt_to;
   assign w_cancel    = !w_idle && (abort || w_timeout);
   assign w_start_acc = w_idle && start;
   assign w_iter_inc  = r_iter_done + ITER_W'(1);
   assign w_last      = (w_iter_inc == r_num_iter);
   assign w_iter_step = (r_state == FLT_WAIT) && w_flt_ret_acc && !w_cancel;
   assign w_finish    = w_iter_step && w_last;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (start && (num_iter != '0)) w_state_next = BUF_CALL;
         BUF_CALL: if (w_buf_call_acc)            w_state_next = BUF_WAIT;
         BUF_WAIT: if (w_buf_ret_acc)             w_state_next = FLT_CALL;
         FLT_CALL: if (w_flt_call_acc)            w_state_next = FLT_WAIT;
         FLT_WAIT: if (w_flt_ret_acc)             w_state_next = w_last ? IDLE : BUF_CALL;
         default:                                 w_state_next = IDLE;
      endcase
      // Abort and timeout both override whatever handshake happened this cycle.
      if (w_cancel) begin
         w_state_next = IDLE;
      end
   end

   always_comb begin
      busy        = !w_idle;
      w_buf_issue = (w_state_next == BUF_CALL) && (r_state != BUF_CALL);
      w_flt_issue = (w_state_next == FLT_CALL) && (r_state != FLT_CALL);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_num_iter    <= '0;
         r_iter_done   <= '0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_done <= (w_start_acc && (num_iter == '0)) || w_finish;
         if (w_start_acc) begin
            r_num_iter    <= num_iter;
            r_iter_done   <= '0;
            r_timeout_err <= 1'b0;
         end else begin
            if (w_iter_step) begin
               r_iter_done <= w_iter_inc;
            end
            // A simultaneous abort suppresses the timeout report.
            if (!w_idle && !abort && w_timeout) begin
               r_timeout_err <= 1'b1;
            end
         end
      end
   end

   assign done        = r_done;
   assign timeout_err = r_timeout_err;
   assign iter_done   = r_iter_done;

   hls_call_port #(
      .TIMEOUT_W      (TIMEOUT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_buf_port (
      .clk               (clk_clk),
      .rst_n             (reset_reset_n),
      .i_issue           (w_buf_issue),
      .i_cancel          (w_cancel),
      .i_idle            (w_idle),
      .bus               (buffer_1),
      .o_call_accepted   (w_buf_call_acc),
      .o_return_accepted (w_buf_ret_acc),
      .o_timed_out       (w_buf_to)
   );

   hls_call_port #(
      .TIMEOUT_W      (TIMEOUT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_flt_port (
      .clk               (clk_clk),
      .rst_n             (reset_reset_n),
      .i_issue           (w_flt_issue),
      .i_cancel          (w_cancel),
      .i_idle            (w_idle),
      .bus               (filter_0),
      .o_call_accepted   (w_flt_call_acc),
      .o_return_accepted (w_flt_ret_acc),
      .o_timed_out       (w_flt_to)
   );

endmodule

// File: tb/tb_hls_call_sequencer.sv
// Bench for hls_call_sequencer: bench-side HLS component responders and a
// run model (call order, phase-length sum, done count, iteration count).
module tb_hls_call_sequencer;

   localparam int ITER_W = 16;
   localparam int TO_CYC = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ITER_W-1:0] num_iter = '0;
   logic              busy, done, timeout_err;
   logic [ITER_W-1:0] iter_done;

   hls_call_if bif ();
   hls_call_if fif ();

   hls_call_sequencer #(
      .ITER_W         (ITER_W),
      .TIMEOUT_W      (24),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .start         (start),
      .abort         (abort),
      .num_iter      (num_iter),
      .busy          (busy),
      .done          (done),
      .timeout_err   (timeout_err),
      .iter_done     (iter_done),
      .buffer_1      (bif),
      .filter_0      (fif)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int call_log[$];
   int n_ret[2];
   int n_done, busy_cnt, exp_cycles, fcv_cyc, to_cyc;
   int stall_left[2], cur_stall[2], ret_wait[2], cur_delay[2];
   int fix_stall[2], fix_delay[2];
   bit ret_pend[2], never_ret[2], cv_pend[2];
   bit rand_mode, hold_chk;
   logic cv_o[2], rs_o[2];

   function automatic int pick_stall(input int c);
      return rand_mode ? int'($urandom_range(0, 3)) : fix_stall[c];
   endfunction

   function automatic int pick_delay(input int c);
      return rand_mode ? int'($urandom_range(0, 3)) : fix_delay[c];
   endfunction

   // Expected call order: buffer_1, filter_0 alternating, 2*n calls.
   function automatic bit order_ok(input int n);
      if (call_log.size() != 2 * n) return 1'b0;
      foreach (call_log[i]) if (call_log[i] != (i % 2)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic prep(input bit rmode, input int s0, input int d0, input int s1,
                       input int d1, input bit nr1, input bit hold);
      rand_mode = rmode;
      hold_chk  = hold;
      fix_stall = '{s0, s1};
      fix_delay = '{d0, d1};
      for (int c = 0; c < 2; c++) begin
         ret_pend[c]   = 1'b0;
         never_ret[c]  = 1'b0;
         cv_pend[c]    = 1'b0;
         cur_stall[c]  = pick_stall(c);
         stall_left[c] = cur_stall[c];
         n_ret[c]      = 0;
      end
      never_ret[1] = nr1;
      call_log.delete();
      n_done = 0; busy_cnt = 0; exp_cycles = 0; fcv_cyc = -1; to_cyc = -1;
      bif.call_stall = 1'b0; bif.return_valid = 1'b0;
      fif.call_stall = 1'b0; fif.return_valid = 1'b0;
   endtask

   // One clock: observe outputs, then play both HLS components for this cycle.
   task automatic tick();
      logic cs[2], rv[2];
      @(posedge clk);
      #1;
      cyc++;
      cv_o[0] = bif.call_valid;   cv_o[1] = fif.call_valid;
      rs_o[0] = bif.return_stall; rs_o[1] = fif.return_stall;
      if (busy) busy_cnt++;
      if (done) n_done++;
      if (timeout_err && to_cyc < 0) to_cyc = cyc;
      if (cv_o[1] && fcv_cyc < 0) fcv_cyc = cyc;
      n_vec++;
      if (done && busy) begin
         n_err++;
         $display("FAIL done_busy_overlap cyc=%0d got done=1 busy=1 want busy=0 with done", cyc);
      end
      for (int c = 0; c < 2; c++) begin
         if (hold_chk && cv_pend[c]) begin
            n_vec++;
            if (cv_o[c] !== 1'b1) begin
               n_err++;
               $display("FAIL call_valid_hold comp=%0d cyc=%0d got %b want 1", c, cyc, cv_o[c]);
            end
         end
         rv[c] = 1'b0;
         if (ret_pend[c]) begin
            if (ret_wait[c] > 0) ret_wait[c]--;
            else begin
               rv[c] = 1'b1;
               if (rs_o[c] == 1'b0) begin
                  ret_pend[c] = 1'b0;
                  n_ret[c]++;
                  exp_cycles += cur_delay[c] + 1;
               end
            end
         end
         cs[c] = 1'b0;
         cv_pend[c] = 1'b0;
         if (cv_o[c] === 1'b1) begin
            if (stall_left[c] > 0) begin
               cs[c] = 1'b1;
               stall_left[c]--;
               cv_pend[c] = 1'b1;
            end else begin
               call_log.push_back(c);
               exp_cycles += cur_stall[c] + 1;
               cur_stall[c] = pick_stall(c);
               stall_left[c] = cur_stall[c];
               if (!never_ret[c]) begin
                  ret_pend[c] = 1'b1;
                  cur_delay[c] = pick_delay(c);
                  ret_wait[c] = cur_delay[c];
               end
            end
         end
      end
      bif.call_stall = cs[0]; bif.return_valid = rv[0];
      fif.call_stall = cs[1]; fif.return_valid = rv[1];
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      num_iter = ITER_W'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && k < 2000) begin
         tick();
         k++;
      end
      n_vec++;
      if (busy) begin
         n_err++;
         $display("FAIL %s_bound busy still %b after %0d cycles want 0", tag, busy, k);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({busy, done, timeout_err} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_status got busy/done/err=%b%b%b want 000", busy, done, timeout_err);
      end
      n_vec++;
      if (iter_done !== '0) begin
         n_err++;
         $display("FAIL reset_iter_done got %0d want 0", iter_done);
      end
      n_vec++;
      if ({bif.call_valid, fif.call_valid, bif.return_stall, fif.return_stall} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_conduits got cv=%b%b rs=%b%b want 0000", bif.call_valid,
                  fif.call_valid, bif.return_stall, fif.return_stall);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      prep(1'b0, 0, 1, 0, 1, 1'b0, 1'b1);
      do_start(3);
      n_vec++;
      if (busy !== 1'b1 || bif.call_valid !== 1'b1) begin
         n_err++;
         $display("FAIL basic_start_latency got busy=%b cv=%b want 1 1", busy, bif.call_valid);
      end
      wait_idle("basic");
      n_vec++;
      if (done !== 1'b1 || n_done != 1) begin
         n_err++;
         $display("FAIL basic_done got done=%b count=%0d want 1 1", done, n_done);
      end
      n_vec++;
      if (iter_done !== 16'd3) begin
         n_err++;
         $display("FAIL basic_iter_done got %0d want 3", iter_done);
      end
      n_vec++;
      if (!order_ok(3) || busy_cnt != exp_cycles) begin
         n_err++;
         $display("FAIL basic_sequence got calls=%0d busy=%0d want calls=6 busy=%0d",
                  call_log.size(), busy_cnt, exp_cycles);
      end
   endtask

   task automatic test_stalls();
      prep(1'b0, 5, 0, 0, 10, 1'b0, 1'b1);
      do_start(1);
      wait_idle("stalls");
      n_vec++;
      if (iter_done !== 16'd1 || n_done != 1) begin
         n_err++;
         $display("FAIL stalls_result got iter=%0d dones=%0d want 1 1", iter_done, n_done);
      end
      n_vec++;
      if (!order_ok(1) || busy_cnt != exp_cycles) begin
         n_err++;
         $display("FAIL stalls_timing got calls=%0d busy=%0d want calls=2 busy=%0d",
                  call_log.size(), busy_cnt, exp_cycles);
      end
   endtask

   task automatic test_zero_iter();
      prep(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      do_start(0);
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || bif.call_valid !== 1'b0) begin
         n_err++;
         $display("FAIL zero_done got done=%b busy=%b cv=%b want 1 0 0", done, busy, bif.call_valid);
      end
      repeat (5) tick();
      n_vec++;
      if (call_log.size() != 0 || n_done != 1 || iter_done !== '0) begin
         n_err++;
         $display("FAIL zero_quiet got calls=%0d dones=%0d iter=%0d want 0 1 0",
                  call_log.size(), n_done, iter_done);
      end
   endtask

   task automatic test_timeout();
      prep(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
      do_start(2);
      wait_idle("timeout");
      n_vec++;
      if (timeout_err !== 1'b1 || (to_cyc - fcv_cyc) != TO_CYC || to_cyc != cyc) begin
         n_err++;
         $display("FAIL timeout_err got err=%b at +%0d want 1 at +%0d", timeout_err,
                  to_cyc - fcv_cyc, TO_CYC);
      end
      n_vec++;
      if (n_done != 0 || iter_done !== '0 || call_log.size() != 2) begin
         n_err++;
         $display("FAIL timeout_aftermath got dones=%0d iter=%0d calls=%0d want 0 0 2",
                  n_done, iter_done, call_log.size());
      end
      prep(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      do_start(1);
      n_vec++;
      if (timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_clear got %b want 0", timeout_err);
      end
      wait_idle("timeout_rerun");
      n_vec++;
      if (iter_done !== 16'd1 || n_done != 1) begin
         n_err++;
         $display("FAIL timeout_rerun got iter=%0d dones=%0d want 1 1", iter_done, n_done);
      end
   endtask

   task automatic test_abort();
      int k = 0;
      prep(1'b0, 0, 3, 0, 0, 1'b0, 1'b0);
      do_start(4);
      while (call_log.size() < 3 && k < 200) begin
         tick();
         k++;
      end
      tick();
      n_vec++;
      if (call_log.size() != 3 || busy !== 1'b1 || bif.return_stall !== 1'b0) begin
         n_err++;
         $display("FAIL abort_reach_wait got calls=%0d busy=%b rs=%b want 3 1 0",
                  call_log.size(), busy, bif.return_stall);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || bif.call_valid !== 1'b0 || fif.call_valid !== 1'b0 || iter_done !== 16'd1) begin
         n_err++;
         $display("FAIL abort_idle got busy=%b cv=%b%b iter=%0d want 0 00 1", busy,
                  bif.call_valid, fif.call_valid, iter_done);
      end
      repeat (8) tick();
      n_vec++;
      if (call_log.size() != 3 || n_done != 0 || n_ret[0] != 2 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_drain got calls=%0d dones=%0d buf_returns=%0d busy=%b want 3 0 2 0",
                  call_log.size(), n_done, n_ret[0], busy);
      end
   endtask

   task automatic test_collisions();
      int k = 0;
      prep(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      do_start(2);
      tick();
      start = 1'b1;
      num_iter = 16'd7;
      tick();
      start = 1'b0;
      wait_idle("start_busy");
      n_vec++;
      if (iter_done !== 16'd2 || n_done != 1 || !order_ok(2)) begin
         n_err++;
         $display("FAIL start_while_busy got iter=%0d dones=%0d calls=%0d want 2 1 4",
                  iter_done, n_done, call_log.size());
      end
      prep(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      do_start(2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || bif.call_valid !== 1'b0 || bif.return_stall !== 1'b0) begin
         n_err++;
         $display("FAIL abort_vs_accept got busy=%b cv=%b rs=%b want 0 0 0", busy,
                  bif.call_valid, bif.return_stall);
      end
      repeat (3) tick();
      prep(1'b0, 0, 0, 6, 0, 1'b0, 1'b0);
      do_start(1);
      while (fif.call_valid !== 1'b1 && k < 100) begin
         tick();
         k++;
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, done, timeout_err, fif.call_valid, bif.return_stall, fif.return_stall} !== 6'b0 ||
          iter_done !== '0 || k >= 100) begin
         n_err++;
         $display("FAIL reset_mid_call got busy=%b cv=%b rs=%b%b waited=%0d want 0 0 00 in FLT_CALL",
                  busy, fif.call_valid, bif.return_stall, fif.return_stall, k);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      prep(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      repeat (3) tick();
      n_vec++;
      if (busy !== 1'b0 || call_log.size() != 0) begin
         n_err++;
         $display("FAIL reset_stays_idle got busy=%b calls=%0d want 0 0", busy, call_log.size());
      end
   endtask

   task automatic test_back_to_back();
      prep(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      do_start(1);
      wait_idle("b2b_first");
      n_vec++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_first_done got %b want 1", done);
      end
      prep(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      do_start(2);
      n_vec++;
      if (busy !== 1'b1 || bif.call_valid !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_restart got busy=%b cv=%b want 1 1", busy, bif.call_valid);
      end
      wait_idle("b2b_second");
      n_vec++;
      if (iter_done !== 16'd2 || n_done != 1 || !order_ok(2) || busy_cnt != exp_cycles) begin
         n_err++;
         $display("FAIL b2b_second got iter=%0d dones=%0d busy=%0d want 2 1 %0d",
                  iter_done, n_done, busy_cnt, exp_cycles);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         int n = int'($urandom_range(1, 4));
         prep(1'b1, 0, 0, 0, 0, 1'b0, 1'b1);
         repeat ($urandom_range(0, 3)) tick();
         do_start(n);
         wait_idle("random");
         n_vec++;
         if (done !== 1'b1 || n_done != 1 || iter_done !== ITER_W'(n) ||
             !order_ok(n) || busy_cnt != exp_cycles) begin
            n_err++;
            $display("FAIL random_run%0d got done=%b dones=%0d iter=%0d calls=%0d busy=%0d want 1 1 %0d %0d %0d",
                     r, done, n_done, iter_done, call_log.size(), busy_cnt, n, 2 * n, exp_cycles);
         end
      end
   endtask

   initial begin
      bif.call_stall = 1'b0; bif.return_valid = 1'b0;
      fif.call_stall = 1'b0; fif.return_valid = 1'b0;
      test_reset();
      test_basic();
      test_stalls();
      test_zero_iter();
      test_timeout();
      test_abort();
      test_collisions();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish by time %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/hls_call_sequencer.md
# hls_call_sequencer

Sequences the two HLS components in the embedded computer system, buffer_1 then filter_0, for a programmable number of iterations per start command. It drives each component's call/return valid-stall handshake, watches every invocation with a timeout counter, and reports busy/done/error status to the controlling processor or top-level logic. It sits beside the system interconnect, wired directly to the buffer_1_* and filter_0_* conduit ports.

## Interface
- ITER_W, 16, width of iteration count and progress counter
- TIMEOUT_W, 24, width of the per-invocation timeout counter
- TIMEOUT_CYCLES, 1000000, cycle limit per call+return; 0 disables the timeout
- clk_clk  in  1  single system clock; all logic is rising-edge
- reset_reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled in IDLE only
- abort  in  1  cancel the current run
- num_iter  in  ITER_W  iterations per run; latched when start is accepted
- busy  out  1  run in progress
- done  out  1  one-cycle pulse on normal completion
- timeout_err  out  1  sticky; set on timeout, cleared when the next start is accepted
- iter_done  out  ITER_W  completed iterations in the current or last run
- buffer_1_call_valid  out  1  call request to buffer_1
- buffer_1_call_stall  in  1  buffer_1 not ready to accept a call
- buffer_1_return_valid  in  1  buffer_1 finished
- buffer_1_return_stall  out  1  back-pressure on buffer_1 return
- filter_0_call_valid, filter_0_call_stall, filter_0_return_valid, filter_0_return_stall: same roles for filter_0

## Operation
- Call handshake: call_valid is held until the call is accepted (valid && !stall). It drops the cycle after acceptance.
- Return handshake: a return is accepted when return_valid && !return_stall.
- return_stall behaviour:
  - 0 in the WAIT state of that component.
  - 0 in IDLE, so stray returns after an abort are drained and ignored.
  - 1 otherwise.
- FSM states: IDLE, BUF_CALL, BUF_WAIT, FLT_CALL, FLT_WAIT.
- Transitions:
  - IDLE -> BUF_CALL on start when num_iter != 0. The start also clears iter_done and timeout_err and latches num_iter.
  - IDLE, start with num_iter == 0: no calls are issued, done pulses next cycle, iter_done = 0.
  - BUF_CALL -> BUF_WAIT on buffer_1 call accept.
  - BUF_WAIT -> FLT_CALL on buffer_1 return accept.
  - FLT_CALL -> FLT_WAIT on filter_0 call accept.
  - FLT_WAIT on filter_0 return accept: iter_done increments. Next state is IDLE with a done pulse if the new count == latched num_iter, else BUF_CALL.
- start while busy: ignored; it does not re-latch num_iter.
- abort in any non-IDLE state:
  - Next state IDLE; call_valid drops next cycle.
  - No done pulse; iter_done holds its value.
  - abort has priority over a simultaneous call or return accept.
- Timeout:
  - The counter clears on entry to each *_CALL state and counts through that CALL and the following WAIT.
  - Reaching TIMEOUT_CYCLES forces IDLE, sets timeout_err, and produces no done.
  - Priority: abort > timeout > handshake accept.
- iter_done wraps modulo 2^ITER_W. This is unreachable because num_iter is the same width.
- Reset mid-run: all state returns to IDLE immediately (asynchronous); a pending HLS call is abandoned.

## Timing
- Reset values:
  - State IDLE.
  - busy = 0, done = 0, timeout_err = 0, iter_done = 0.
  - Both call_valid = 0, both return_stall = 0.
- All outputs are registered, or decoded from registered state only. No input-to-output combinational path.
- start accepted at edge N: busy = 1 and buffer_1_call_valid = 1 from cycle N+1.
- State change to the next phase happens one cycle after each accept.
- Minimum iteration: 4 cycles (zero stall, return_valid already high in WAIT).
- Final filter_0 return accepted at edge M: done = 1 and busy = 0 in cycle M+1 only; iter_done is updated in the same cycle.
- Back-to-back runs: start may be accepted in the same cycle done is high; busy reasserts the next cycle.

## Structure
- Package hls_seq_pkg holds:
  - the state enum (IDLE, BUF_CALL, BUF_WAIT, FLT_CALL, FLT_WAIT);
  - default ITER_W and TIMEOUT_W constants.
- Sub-module hls_call_port, instantiated once per component, contains:
  - call_valid/return_stall generation;
  - accept detection;
  - per-invocation timeout counter.
- It takes issue/cancel inputs from the top FSM and returns call_accepted, return_accepted and timed_out pulses.
- The top level holds the FSM, the num_iter latch, iter_done and the status outputs.

## Test plan
- Basic run: num_iter = 3, zero stall, returns 2 cycles after each call accept -> six calls in order buf, flt, buf, flt, buf, flt; done pulses once; iter_done = 3; busy falls with done.
- Stalls: buffer_1_call_stall high for 5 cycles, filter_0 return_valid delayed 10 cycles -> call_valid held steady throughout; no early state change; iter_done = 1 for num_iter = 1.
- num_iter = 0: start -> no call_valid ever; done pulses on cycle N+1; iter_done = 0.
- Timeout: TIMEOUT_CYCLES = 16, filter_0 never returns -> timeout_err = 1 at cycle 16 of that invocation; busy = 0; no done. The next start clears timeout_err.
- Abort: abort asserted in BUF_WAIT of iteration 2 with num_iter = 4 -> IDLE next cycle; iter_done = 1; no done. A stray buffer_1 return afterwards is drained (return_stall = 0) without starting any new call.
- Collisions and reset:
  - start during busy -> ignored.
  - abort in the same cycle as a call accept -> abort wins.
  - reset_reset_n low mid-FLT_CALL -> all outputs at reset values immediately.
